// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared types and sizing helpers for the Vedic partial-product accumulator
package vedic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Width of the product returned by the external 2x2 cell.
  localparam int PP_W = 4;

  function automatic int num_digits(input int width);
    return width / 2;
  endfunction

  function automatic int num_steps(input int width);
    return (width / 2) * (width / 2);
  endfunction

  function automatic int step_bits(input int width);
    return (num_steps(width) > 1) ? $clog2(num_steps(width)) : 1;
  endfunction

endpackage

// File: rtl/vedic_pp_accumulator_if.sv
// rtl/vedic_pp_accumulator_if.sv - start/operand/result handshake of the sequential multiplier
interface vedic_pp_accumulator_if #(
  parameter int WIDTH = 4
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/vedic_pp_check.sv
// rtl/vedic_pp_check.sv - reference compare of the 2x2 cell output with a sticky error flag
module vedic_pp_check
  import vedic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            check_en,
  input  logic [1:0]      pp_a,
  input  logic [1:0]      pp_b,
  input  logic [PP_W-1:0] pp_q,
  output logic            pp_err
);

  logic [PP_W-1:0] expected;

  assign expected = {2'b00, pp_a} * {2'b00, pp_b};

  // Only reset clears the flag; a new start leaves it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_err <= 1'b0;
    end else if (check_en && (pp_q != expected)) begin
      pp_err <= 1'b1;
    end
  end

endmodule

// File: rtl/vedic_pp_accumulator.sv
// rtl/vedic_pp_accumulator.sv - WIDTH x WIDTH multiplier stepping digit pairs through an external 2x2 cell
// Optional cell checker built when VEDIC_PP_CHECK_EN is defined.
module vedic_pp_accumulator
  import vedic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vedic_pp_accumulator_if.slave  bus,
  output logic [1:0]             pp_a,
  output logic [1:0]             pp_b,
  input  logic [PP_W-1:0]        pp_q,
  output logic                   pp_err
);

  localparam int unsigned D     = num_digits(WIDTH);
  localparam int unsigned S     = num_steps(WIDTH);
  localparam int          SW    = step_bits(WIDTH);
  localparam int          ACC_W = 2 * WIDTH;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   term;
  logic [ACC_W-1:0]   product_reg;
  logic [SW-1:0]      step;
  logic [31:0]        step_ext;
  logic [31:0]        i_idx;
  logic [31:0]        j_idx;
  logic               last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    step_ext   = 32'(step);
    i_idx      = step_ext % D;
    j_idx      = step_ext / D;
    last_step  = (step == SW'(S - 1));
    pp_a       = 2'b00;
    pp_b       = 2'b00;
    term       = ACC_W'(pp_q) << (2 * (i_idx + j_idx));
    acc_sum    = acc + term;

    case (state)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        pp_a = 2'(a_reg >> (2 * i_idx));
        pp_b = 2'(b_reg >> (2 * j_idx));
        if (last_step) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every run takes all S steps, even for zero operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      step        <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            acc   <= '0;
            step  <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (last_step) begin
            product_reg <= acc_sum;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = product_reg;

`ifdef VEDIC_PP_CHECK_EN
  vedic_pp_check u_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .check_en (state == RUN),
    .pp_a     (pp_a),
    .pp_b     (pp_b),
    .pp_q     (pp_q),
    .pp_err   (pp_err)
  );
`else
  assign pp_err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_pp_accumulator.sv
// tb/tb_vedic_pp_accumulator.sv - directed-vector bench with a gate-level 2x2 cell on the pp_* ports
module tb_vedic_pp_accumulator;

  logic       clk;
  logic       rst_n;
  logic [1:0] pp_a;
  logic [1:0] pp_b;
  logic [3:0] pp_q;
  logic [3:0] cell_q;
  logic       pp_err;
  logic       force_q;
  int         vectors;
  int         miscompares;

  vedic_pp_accumulator_if #(.WIDTH(4)) bus_if ();

  vedic_pp_accumulator #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .pp_a   (pp_a),
    .pp_b   (pp_b),
    .pp_q   (pp_q),
    .pp_err (pp_err)
  );

  // Gate-level 2x2 Vedic cell
  logic c0, c1, c2, c3;
  assign c0 = pp_a[0] & pp_b[0];
  assign c1 = pp_a[1] & pp_b[0];
  assign c2 = pp_a[0] & pp_b[1];
  assign c3 = pp_a[1] & pp_b[1];
  assign cell_q[0] = c0;
  assign cell_q[1] = c1 ^ c2;
  assign cell_q[2] = c3 ^ (c1 & c2);
  assign cell_q[3] = c3 & c1 & c2;
  assign pp_q = force_q ? 4'hF : cell_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input logic check_product);
    int runs;
    int guard;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    runs  = 0;
    guard = 0;
    while (!bus_if.done && guard < 20) begin
      if (bus_if.busy) runs++;
      tick();
      guard++;
    end
    check_val({tag, "_done"}, 32'(bus_if.done), 32'd1);
    check_val({tag, "_run_cycles"}, 32'(runs), 32'd4);
    if (check_product) check_val({tag, "_product"}, 32'(bus_if.product), 32'(exp));
    tick();
    check_val({tag, "_idle_after"}, {30'd0, bus_if.busy, bus_if.done}, 32'd0);
  endtask

  initial begin
    int busy_seen;
    vectors      = 0;
    miscompares  = 0;
    force_q      = 1'b0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1. reset state and idle
    check_val("rst_busy",    32'(bus_if.busy),    32'd0);
    check_val("rst_done",    32'(bus_if.done),    32'd0);
    check_val("rst_product", 32'(bus_if.product), 32'd0);
    check_val("rst_pp_ab",   {28'd0, pp_a, pp_b}, 32'd0);
    check_val("rst_pp_err",  32'(pp_err),         32'd0);
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_if.busy) busy_seen++;
    end
    check_val("idle_busy", 32'(busy_seen), 32'd0);

    // 2. 13 x 11: four RUN cycles, done on the fifth
    bus_if.a     = 4'd13;
    bus_if.b     = 4'd11;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = 4'd0;
    bus_if.b     = 4'd0;
    check_val("t2_step0_pp", {28'd0, pp_a, pp_b}, {28'd0, 2'd1, 2'd3});
    for (int c = 1; c <= 3; c++) begin
      check_val("t2_busy_run", {30'd0, bus_if.busy, bus_if.done}, 32'd2);
      tick();
      if (c == 1) check_val("t2_step1_pp", {28'd0, pp_a, pp_b}, {28'd0, 2'd3, 2'd3});
      if (c == 3) check_val("t2_step3_pp", {28'd0, pp_a, pp_b}, {28'd0, 2'd3, 2'd2});
    end
    check_val("t2_busy_run4", {30'd0, bus_if.busy, bus_if.done}, 32'd2);
    tick();
    check_val("t2_done_c5",  {30'd0, bus_if.busy, bus_if.done}, 32'd3);
    check_val("t2_product",  32'(bus_if.product), 32'd143);
    check_val("t2_pp_done",  {28'd0, pp_a, pp_b}, 32'd0);
    tick();
    check_val("t2_idle",     {30'd0, bus_if.busy, bus_if.done}, 32'd0);
    tick();
    tick();
    check_val("t2_held",     32'(bus_if.product), 32'd143);

    // 3. extremes and zero operand
    run_op("t3_15x15", 4'd15, 4'd15, 8'd225, 1'b1);
    run_op("t3_0x9",   4'd0,  4'd9,  8'd0,   1'b1);
    run_op("t3_9x0",   4'd9,  4'd0,  8'd0,   1'b1);

    // 4. start while busy and in DONE is ignored
    bus_if.a     = 4'd3;
    bus_if.b     = 4'd5;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = 4'd7;
    bus_if.b     = 4'd7;
    for (int c = 1; c <= 6; c++) begin
      bus_if.start = (c == 2 || c == 5);
      tick();
    end
    bus_if.start = 1'b0;
    check_val("t4_product", 32'(bus_if.product), 32'd15);
    tick();
    check_val("t4_no_restart", 32'(bus_if.busy), 32'd0);

    // 5. reset mid-run
    bus_if.a     = 4'd12;
    bus_if.b     = 4'd10;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_val("t5_abort_busy",    32'(bus_if.busy),    32'd0);
    check_val("t5_abort_product", 32'(bus_if.product), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("t5_2x2", 4'd2, 4'd2, 8'd4, 1'b1);

    // 6. corrupted cell output
    force_q = 1'b1;
    run_op("t6_forced", 4'd1, 4'd1, 8'd0, 1'b0);
    force_q = 1'b0;
    run_op("t6_clean", 4'd1, 4'd1, 8'd1, 1'b1);
`ifdef VEDIC_PP_CHECK_EN
    check_val("t6_pp_err", 32'(pp_err), 32'd1);
`else
    check_val("t6_pp_err", 32'(pp_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
